violation_ctrl: RTL and testbench

Violation controller for the clock recovery/generation datapath. It collects the eleven violation flags from recovery and generation plus a loss-of-lock event, and classifies each source as Ignore, Warning or Error through CSR-style registers. Sources can be muted automatically until `fully_locked_in` asserts. It holds sticky status and per-source occurrence counters, and drives separate Error and Warning interrupt lines that stay high until software reads the status register.

---
 rtl/violation_ctrl_pkg.sv | 78 +++++++
 rtl/violation_ctrl_channel.sv | 66 ++++++
 rtl/violation_ctrl.sv | 130 +++++++++++++
 tb/tb_violation_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/violation_ctrl_pkg.sv
// Shared types for the clock recovery/generation violation controller.
//   common_p    : clock-domain bundle (clock + async active-low reset).
//   clks_alot_p : violation source indices, classification codes, register
//                 addresses, configuration structs and reset values.
package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int VIOL_COUNT     = 12;
    localparam int VIOL_RAW_COUNT = 11;

    typedef enum logic [3:0] {
        VIOL_HI_BP_OVER         = 4'd0,
        VIOL_HI_BP_UNDER        = 4'd1,
        VIOL_LO_BP_OVER         = 4'd2,
        VIOL_LO_BP_UNDER        = 4'd3,
        VIOL_HI_POS_DRIFT       = 4'd4,
        VIOL_HI_NEG_DRIFT       = 4'd5,
        VIOL_LO_POS_DRIFT       = 4'd6,
        VIOL_LO_NEG_DRIFT       = 4'd7,
        VIOL_EXC_DRIFT          = 4'd8,
        VIOL_EXP_DELTA_MISMATCH = 4'd9,
        VIOL_PRE_DELTA_MISMATCH = 4'd10,
        VIOL_LOCK_LOST          = 4'd11
    } viol_idx_e;

    typedef enum logic [1:0] {
        CLS_IGNORE    = 2'd0,
        CLS_WARNING   = 2'd1,
        CLS_ERROR     = 2'd2,
        CLS_ERROR_ALT = 2'd3   // decoded exactly like CLS_ERROR
    } viol_class_e;

    localparam logic [3:0] VIOL_ADDR_STATUS       = 4'd0;
    localparam logic [3:0] VIOL_ADDR_CLASS        = 4'd1;
    localparam logic [3:0] VIOL_ADDR_PRELOCK_MUTE = 4'd2;
    localparam logic [3:0] VIOL_ADDR_CTRL         = 4'd3;
    localparam logic [3:0] VIOL_ADDR_COUNT0       = 4'd4;

    // Packed MSB-first, so auto_mute_en lands on bit 0.
    typedef struct packed {
        logic warn_irq_en;
        logic err_irq_en;
        logic auto_mute_en;
    } viol_ctrl_s;

    typedef struct packed {
        logic [2*VIOL_COUNT-1:0] cls;
        logic [VIOL_COUNT-1:0]   prelock_mute;
        viol_ctrl_s              ctrl;
    } viol_cfg_s;

    localparam logic [2*VIOL_COUNT-1:0] VIOL_CLASS_RST   = 24'h555555;
    localparam logic [VIOL_COUNT-1:0]   VIOL_PRELOCK_RST = 12'hFFF;
    localparam viol_ctrl_s              VIOL_CTRL_RST    = '{warn_irq_en: 1'b1,
                                                            err_irq_en:  1'b1,
                                                            auto_mute_en: 1'b1};
    localparam viol_cfg_s               VIOL_CFG_RST     = '{cls:          VIOL_CLASS_RST,
                                                            prelock_mute: VIOL_PRELOCK_RST,
                                                            ctrl:         VIOL_CTRL_RST};

    // Per-source "counts as error" vector (codes 2 and 3).
    function automatic logic [VIOL_COUNT-1:0] class_err_mask(input logic [2*VIOL_COUNT-1:0] cls);
        logic [VIOL_COUNT-1:0] m;
        for (int i = 0; i < VIOL_COUNT; i++) m[i] = cls[2*i+1];
        return m;
    endfunction

    function automatic logic [VIOL_COUNT-1:0] class_warn_mask(input logic [2*VIOL_COUNT-1:0] cls);
        logic [VIOL_COUNT-1:0] m;
        for (int i = 0; i < VIOL_COUNT; i++) m[i] = (cls[2*i +: 2] == CLS_WARNING);
        return m;
    endfunction
endpackage

// File: rtl/violation_ctrl_channel.sv
// violation_channel: one violation source.
//   raw        : source level (or lock-lost pulse)
//   enable     : global capture enable
//   cls        : registered class code for this source
//   mute_req   : pre-lock mute request (ignored when MUTE_EXEMPT)
//   clear      : synchronous clear of sticky bit, counter and edge history
//   rd_clr     : STATUS is being read this cycle
//   cnt_clr    : this source's COUNT register is being written
//   ev         : unmasked event, this cycle
//   status_nxt : next-state sticky bit (used for interrupt reduction)
//   status     : sticky bit
//   count      : saturating rising-edge counter
module violation_channel
    import clks_alot_p::*;
#(
    parameter int CNT_W       = 8,
    parameter bit MUTE_EXEMPT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw,
    input  logic             enable,
    input  logic [1:0]       cls,
    input  logic             mute_req,
    input  logic             clear,
    input  logic             rd_clr,
    input  logic             cnt_clr,
    output logic             ev,
    output logic             status_nxt,
    output logic             status,
    output logic [CNT_W-1:0] count
);
    logic masked;
    logic prev_q;
    logic rise;
    logic cnt_sat;

    assign masked  = (cls == CLS_IGNORE) | ~enable | (mute_req & ~MUTE_EXEMPT);
    assign ev      = raw & ~masked;
    assign rise    = ev & ~prev_q;
    assign cnt_sat = &count;

    // A STATUS read returns the whole vector, so every set bit is consumed;
    // only an event in the same cycle re-arms it.
    always_comb begin
        status_nxt = status | ev;
        if (rd_clr) status_nxt = ev;
        if (clear)  status_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 1'b0;
            prev_q <= 1'b0;
            count  <= '0;
        end else begin
            status <= status_nxt;
            // A cleared cycle is treated as if no event happened.
            prev_q <= clear ? 1'b0 : ev;
            if (clear || cnt_clr)
                count <= '0;
            else if (rise && !cnt_sat)
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/violation_ctrl.sv
// violation_ctrl: classifies recovery/generation violations and loss of lock.
//   sys_dom_i         : clock + async active-low reset
//   enable_i          : capture enable
//   clear_state_i     : clear STATUS, COUNT and lock-edge history
//   violations_i      : 11 raw violation levels (viol_idx_e order)
//   fully_locked_in_i : lock status from recovery
//   wr_*/rd_*         : register port, 1-cycle read latency
//   err_irq_o/warn_irq_o : sticky-status interrupts, registered
//   active_o          : registered unmasked event vector (debug)
module violation_ctrl
    import clks_alot_p::*;
#(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 32
) (
    input  common_p::clk_dom_s         sys_dom_i,
    input  logic                       enable_i,
    input  logic                       clear_state_i,
    input  logic [VIOL_RAW_COUNT-1:0]  violations_i,
    input  logic                       fully_locked_in_i,
    input  logic                       wr_en_i,
    input  logic [3:0]                 wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    input  logic [3:0]                 rd_addr_i,
    output logic                       rd_valid_o,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       err_irq_o,
    output logic                       warn_irq_o,
    output logic [VIOL_COUNT-1:0]      active_o
);
    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    viol_cfg_s                        cfg_q, cfg_d;
    logic                             lock_q, lock_prev_q, lock_lost;
    logic [VIOL_COUNT-1:0]            raw, mute_req, cnt_clr;
    logic [VIOL_COUNT-1:0]            ev, status, status_nxt;
    logic [VIOL_COUNT-1:0][CNT_W-1:0] count;
    logic                             rd_clr;
    logic [3:0]                       cnt_idx;
    logic [DATA_W-1:0]                rd_d;
    logic                             err_d, warn_d;
    logic                             unused_wdata;

    assign unused_wdata = ^wr_data_i[DATA_W-1:2*VIOL_COUNT];

    // Loss of lock is a falling edge of the registered lock.
    assign lock_lost = lock_prev_q & ~lock_q;
    assign raw       = {lock_lost, violations_i};
    assign mute_req  = {VIOL_COUNT{cfg_q.ctrl.auto_mute_en & ~lock_q}} & cfg_q.prelock_mute;
    assign rd_clr    = rd_en_i && (rd_addr_i == VIOL_ADDR_STATUS);

    always_comb begin
        cfg_d = cfg_q;
        if (wr_en_i) begin
            case (wr_addr_i)
                VIOL_ADDR_CLASS:        cfg_d.cls          = wr_data_i[2*VIOL_COUNT-1:0];
                VIOL_ADDR_PRELOCK_MUTE: cfg_d.prelock_mute = wr_data_i[VIOL_COUNT-1:0];
                VIOL_ADDR_CTRL:         cfg_d.ctrl         = viol_ctrl_s'(wr_data_i[2:0]);
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < VIOL_COUNT; gi++) begin : g_ch
        assign cnt_clr[gi] = wr_en_i && (wr_addr_i == VIOL_ADDR_COUNT0 + 4'(gi));

        violation_channel #(
            .CNT_W       (CNT_W),
            .MUTE_EXEMPT (gi == int'(VIOL_LOCK_LOST))
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw[gi]),
            .enable     (enable_i),
            .cls        (cfg_q.cls[2*gi +: 2]),
            .mute_req   (mute_req[gi]),
            .clear      (clear_state_i),
            .rd_clr     (rd_clr),
            .cnt_clr    (cnt_clr[gi]),
            .ev         (ev[gi]),
            .status_nxt (status_nxt[gi]),
            .status     (status[gi]),
            .count      (count[gi])
        );
    end

    // Interrupts follow next-state STATUS and configuration, so they move on
    // the same edge as the sticky bit or a reclassification.
    assign err_d  = cfg_d.ctrl.err_irq_en  & |(status_nxt & class_err_mask(cfg_d.cls));
    assign warn_d = cfg_d.ctrl.warn_irq_en & |(status_nxt & class_warn_mask(cfg_d.cls));

    // Read mux sees pre-write values.
    assign cnt_idx = rd_addr_i - VIOL_ADDR_COUNT0;
    always_comb begin
        rd_d = '0;
        case (rd_addr_i)
            VIOL_ADDR_STATUS:       rd_d[VIOL_COUNT-1:0]   = status;
            VIOL_ADDR_CLASS:        rd_d[2*VIOL_COUNT-1:0] = cfg_q.cls;
            VIOL_ADDR_PRELOCK_MUTE: rd_d[VIOL_COUNT-1:0]   = cfg_q.prelock_mute;
            VIOL_ADDR_CTRL:         rd_d[2:0]              = cfg_q.ctrl;
            default:                rd_d[CNT_W-1:0]        = count[cnt_idx];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= VIOL_CFG_RST;
            lock_q      <= 1'b0;
            lock_prev_q <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            err_irq_o   <= 1'b0;
            warn_irq_o  <= 1'b0;
            active_o    <= '0;
        end else begin
            cfg_q       <= cfg_d;
            lock_q      <= fully_locked_in_i;
            lock_prev_q <= clear_state_i ? 1'b0 : lock_q;
            rd_valid_o  <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_d;
            err_irq_o   <= err_d;
            warn_irq_o  <= warn_d;
            active_o    <= ev;
        end
    end
endmodule

// File: tb/tb_violation_ctrl.sv
module tb_violation_ctrl;
    import common_p::*;

    localparam int CNT_W  = 8;
    localparam int DATA_W = 32;
    localparam int NS     = 12;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_dom_s sys_dom;
    assign sys_dom = clk_dom_s'({clk, rst_n});

    logic              enable_i, clear_state_i, fully_locked_in_i;
    logic [10:0]       violations_i;
    logic              wr_en_i, rd_en_i;
    logic [3:0]        wr_addr_i, rd_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_valid_o, err_irq_o, warn_irq_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [NS-1:0]     active_o;

    violation_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .sys_dom_i         (sys_dom),
        .enable_i          (enable_i),
        .clear_state_i     (clear_state_i),
        .violations_i      (violations_i),
        .fully_locked_in_i (fully_locked_in_i),
        .wr_en_i           (wr_en_i),
        .wr_addr_i         (wr_addr_i),
        .wr_data_i         (wr_data_i),
        .rd_en_i           (rd_en_i),
        .rd_addr_i         (rd_addr_i),
        .rd_valid_o        (rd_valid_o),
        .rd_data_o         (rd_data_o),
        .err_irq_o         (err_irq_o),
        .warn_irq_o        (warn_irq_o),
        .active_o          (active_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [NS-1:0] m_status, m_prev;
    int          m_count[NS];
    bit          m_lock, m_lprev;
    bit [23:0]   m_class;
    bit [11:0]   m_pre;
    bit [2:0]    m_ctrl;

    typedef struct {
        bit          rv;
        bit          err;
        bit          warn;
        bit [NS-1:0] act;
    } cyc_t;
    cyc_t      cyc_q[$];
    bit [31:0] rd_q[$];

    // stimulus for the next cycle
    bit [10:0] g_viol;
    bit        g_lock, g_en, g_clr, g_we, g_re;
    bit [3:0]  g_wa, g_ra;
    bit [31:0] g_wd;

    task automatic model_reset();
        m_status = '0; m_prev = '0; m_lock = 0; m_lprev = 0;
        m_class = 24'h555555; m_pre = 12'hFFF; m_ctrl = 3'h7;
        for (int i = 0; i < NS; i++) m_count[i] = 0;
    endtask

    function automatic int cls_of(input bit [23:0] c, input int i);
        return int'((c >> (2*i)) & 24'h3);
    endfunction

    task automatic step();
        bit [NS-1:0] ev;
        bit          lost, raw, muted, err, warn;
        bit [31:0]   rdv;
        cyc_t        e;
        @(negedge clk);
        violations_i = g_viol; fully_locked_in_i = g_lock; enable_i = g_en;
        clear_state_i = g_clr; wr_en_i = g_we; wr_addr_i = g_wa; wr_data_i = g_wd;
        rd_en_i = g_re; rd_addr_i = g_ra;

        lost = m_lprev && !m_lock;
        for (int i = 0; i < NS; i++) begin
            raw   = (i < 11) ? g_viol[i] : lost;
            muted = (i != 11) && m_ctrl[0] && m_pre[i] && !m_lock;
            ev[i] = raw && g_en && (cls_of(m_class, i) != 0) && !muted;
        end
        if (g_re) begin
            case (g_ra)
                4'd0:    rdv = 32'(m_status);
                4'd1:    rdv = 32'(m_class);
                4'd2:    rdv = 32'(m_pre);
                4'd3:    rdv = 32'(m_ctrl);
                default: rdv = 32'(m_count[int'(g_ra) - 4]);
            endcase
            rd_q.push_back(rdv);
        end
        if (g_clr) m_status = '0;
        else begin
            if (g_re && g_ra == 0) m_status = '0;
            m_status |= ev;
        end
        for (int i = 0; i < NS; i++) begin
            if (g_clr || (g_we && int'(g_wa) == i + 4)) m_count[i] = 0;
            else if (ev[i] && !m_prev[i] && m_count[i] < CMAX) m_count[i]++;
        end
        m_prev = g_clr ? '0 : ev;
        if (g_we && g_wa == 1) m_class = g_wd[23:0];
        if (g_we && g_wa == 2) m_pre   = g_wd[11:0];
        if (g_we && g_wa == 3) m_ctrl  = g_wd[2:0];
        m_lprev = g_clr ? 1'b0 : m_lock;
        m_lock  = g_lock;
        err = 0; warn = 0;
        for (int i = 0; i < NS; i++)
            if (m_status[i]) begin
                if (cls_of(m_class, i) >= 2) err = 1;
                if (cls_of(m_class, i) == 1) warn = 1;
            end
        e.rv = g_re; e.err = err && m_ctrl[1]; e.warn = warn && m_ctrl[2]; e.act = ev;
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask
    task automatic rd(input bit [3:0] a);
        g_re = 1; g_ra = a; step(); g_re = 0;
    endtask
    task automatic wr(input bit [3:0] a, input bit [31:0] d);
        g_we = 1; g_wa = a; g_wd = d; step(); g_we = 0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        cyc_t e;
        #1;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("rd_valid", 32'(rd_valid_o), 32'(e.rv));
            chk("err_irq",  32'(err_irq_o),  32'(e.err));
            chk("warn_irq", 32'(warn_irq_o), 32'(e.warn));
            chk("active",   32'(active_o),   32'(e.act));
            if (rd_valid_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid_o), 32'd0);
                else chk("rd_data", rd_data_o, rd_q.pop_front());
            end
        end
    end

    task automatic hold_reset();
        violations_i = '0; fully_locked_in_i = 0; enable_i = 0; clear_state_i = 0;
        wr_en_i = 0; wr_addr_i = '0; wr_data_i = '0; rd_en_i = 0; rd_addr_i = '0;
        g_viol = '0; g_lock = 0; g_en = 1; g_clr = 0; g_we = 0; g_re = 0;
        g_wa = '0; g_ra = '0; g_wd = '0;
        model_reset();
    endtask

    initial begin
        rst_n = 0;
        hold_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid_o), 0);
        chk("rst_rd_data",  rd_data_o, 0);
        chk("rst_irqs",     32'({err_irq_o, warn_irq_o}), 0);
        chk("rst_active",   32'(active_o), 0);
        #1 rst_n = 1;

        // reset configuration readback, incl. back-to-back reads
        rd(1); rd(2); rd(3); rd(0); rd(4);
        idle(2);

        // pre-lock muting of source 4, then unmuted after lock
        g_viol = 11'h010; idle(3); g_viol = '0;
        rd(0); rd(8);
        g_lock = 1; idle(3);
        g_viol = 11'h010; idle(3); g_viol = '0;
        idle(1);
        rd(0); rd(8); idle(2);

        // source 8 as error, held through a status read
        wr(1, 32'h555555 & ~(32'h3 << 16) | (32'h2 << 16));
        g_viol = 11'h100; idle(2);
        rd(0); idle(2);
        g_viol = '0; idle(1);
        rd(0); idle(3);

        // counter saturation and write-vs-increment priority
        for (int k = 0; k < 300; k++) begin
            g_viol = 11'h001; step();
            g_viol = '0;      step();
        end
        rd(4);
        g_viol = 11'h001; wr(4, 32'hDEAD); g_viol = '0;
        rd(4); idle(1);

        // loss of lock with everything pre-lock muted
        wr(2, 32'hFFF);
        g_viol = 11'h7FF; idle(2); g_viol = '0;
        g_lock = 0; idle(1); rd(0); idle(3); rd(0);
        g_lock = 1; idle(3);

        // clear_state with a coincident event
        g_viol = 11'h003; idle(2);
        g_clr = 1; step(); g_clr = 0; g_viol = '0;
        rd(0); rd(1); rd(4); rd(5); idle(2);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(1, 0) == 1) g_viol = 11'($urandom & $urandom);
            if ($urandom_range(39, 0) == 0) g_lock = ~g_lock;
            g_en  = ($urandom_range(19, 0) != 0);
            g_clr = ($urandom_range(59, 0) == 0);
            g_we  = ($urandom_range(5, 0) == 0);
            g_wa  = 4'($urandom);
            g_wd  = $urandom;
            g_re  = ($urandom_range(1, 0) == 1);
            g_ra  = 4'($urandom);
            step();
        end
        g_we = 0; g_re = 0; g_clr = 0; g_en = 1;

        // get a pending warning, then reset with a read in flight
        wr(1, 32'h555555); wr(3, 32'h7);
        g_lock = 1; g_viol = 11'h7FF; idle(3); g_viol = '0; idle(1);
        @(posedge clk); #2;
        chk("pre_reset_warn", 32'(warn_irq_o), 1);
        @(negedge clk);
        rd_en_i = 1; rd_addr_i = 4'd1;
        #2 rst_n = 0;
        #1;
        chk("async_rst_irqs",   32'({err_irq_o, warn_irq_o}), 0);
        chk("async_rst_active", 32'(active_o), 0);
        @(posedge clk); #1;
        chk("async_rst_no_rd",  32'(rd_valid_o), 0);
        hold_reset();
        @(posedge clk); #2 rst_n = 1;
        rd(1); rd(2); rd(3); rd(0);
        idle(3);

        repeat (3) @(posedge clk);
        #2;
        chk("cyc_q_drained", 32'(cyc_q.size()), 0);
        chk("rd_q_drained",  32'(rd_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
